// File: rtl/seg_note_pkg.sv
// Shared constants, FSM state type and segment decoder for the note display receive path.
package seg_note_pkg;

  localparam int unsigned SEG_W    = 7;
  localparam int unsigned CODE_W   = 3;
  localparam int unsigned SAMPLE_W = SEG_W + 1;
  localparam int unsigned CNT_W    = 4;

  // Segment patterns, bit 6 = a ... bit 0 = g
  localparam logic [SEG_W-1:0] SEG_C     = 7'b1001110;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b0111101;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b1000111;
  localparam logic [SEG_W-1:0] SEG_G     = 7'b1011110;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b1110111;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b0011111;
  localparam logic [SEG_W-1:0] SEG_REST  = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  localparam logic [CODE_W-1:0] NOTE_C    = 3'd0;
  localparam logic [CODE_W-1:0] NOTE_D    = 3'd1;
  localparam logic [CODE_W-1:0] NOTE_E    = 3'd2;
  localparam logic [CODE_W-1:0] NOTE_F    = 3'd3;
  localparam logic [CODE_W-1:0] NOTE_G    = 3'd4;
  localparam logic [CODE_W-1:0] NOTE_A    = 3'd5;
  localparam logic [CODE_W-1:0] NOTE_B    = 3'd6;
  localparam logic [CODE_W-1:0] NOTE_REST = 3'd7;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  typedef struct packed {
    logic              legal;
    logic              blank;
    logic [CODE_W-1:0] code;
  } seg_decode_t;

  // Map a segment pattern to its note code; blank is legal but carries no note
  function automatic seg_decode_t seg_decode(input logic [SEG_W-1:0] seg);
    seg_decode_t d;
    d.legal = 1'b1;
    d.blank = 1'b0;
    d.code  = NOTE_C;
    case (seg)
      SEG_C:     d.code  = NOTE_C;
      SEG_D:     d.code  = NOTE_D;
      SEG_E:     d.code  = NOTE_E;
      SEG_F:     d.code  = NOTE_F;
      SEG_G:     d.code  = NOTE_G;
      SEG_A:     d.code  = NOTE_A;
      SEG_B:     d.code  = NOTE_B;
      SEG_REST:  d.code  = NOTE_REST;
      SEG_BLANK: d.blank = 1'b1;
      default:   d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg_stability_filter.sv
// Debounce filter: emits one registered accept pulse per run of identical samples.
module seg_stability_filter
  import seg_note_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                accept,
  output logic [SAMPLE_W-1:0] value
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [SAMPLE_W-1:0] prev;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_next;
  logic                hit;

  // Restart on any change, otherwise count up and saturate at the threshold
  always_comb begin
    cnt_next = cnt;
    if (sample != prev) begin
      cnt_next = CNT_W'(1);
    end else if (cnt < CNT_MAX) begin
      cnt_next = cnt + CNT_W'(1);
    end
  end

  // Accept only on the cycle the counter first reaches the threshold
  assign hit = (cnt_next == CNT_MAX) && (cnt != CNT_MAX);

  // Sample history, counter and accepted value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev   <= '0;
      cnt    <= '0;
      accept <= 1'b0;
      value  <= '0;
    end else begin
      prev   <= sample;
      cnt    <= cnt_next;
      accept <= hit;
      if (hit) begin
        value <= sample;
      end
    end
  end

endmodule

// File: rtl/seg_note_decoder.sv
// Recovers note code and tone bit from a filtered 7-segment+DP bus, delivered via valid/ready.
module seg_note_decoder
  import seg_note_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [SEG_W-1:0]  SAIDA,
  input  logic              DP,
  output logic [CODE_W-1:0] NOTAS,
  output logic              TOM,
  output logic              Valid,
  input  logic              Ready,
  output logic              Erro,
  output logic              Overrun
);

  logic                acc;
  logic [SAMPLE_W-1:0] acc_value;
  seg_decode_t         dec;
  state_t              state;
  state_t              state_next;
  logic                mem_valid;
  logic [CODE_W:0]     mem_note;
  logic [CODE_W:0]     acc_note;
  logic                is_new;
  logic                load;
  logic                overrun_set;

  seg_stability_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk   (Clock),
    .rst_n (Reset_n),
    .sample({DP, SAIDA}),
    .accept(acc),
    .value (acc_value)
  );

  assign dec      = seg_decode(acc_value[SEG_W-1:0]);
  assign acc_note = {acc_value[SAMPLE_W-1], dec.code};
  assign is_new   = dec.legal && !dec.blank && (!mem_valid || (mem_note != acc_note));
  assign Valid    = (state == HOLD);

  // Next state plus load/overrun decisions; a handshake frees the slot for a same-cycle reload
  always_comb begin
    state_next  = state;
    load        = 1'b0;
    overrun_set = 1'b0;
    case (state)
      IDLE: begin
        if (acc && is_new) begin
          load       = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (acc && is_new) begin
          if (Ready) begin
            load = 1'b1;
          end else begin
            overrun_set = 1'b1;
          end
        end
        if (Ready && !load) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, output registers, last-note memory and flags
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      NOTAS     <= '0;
      TOM       <= 1'b0;
      Erro      <= 1'b0;
      Overrun   <= 1'b0;
      mem_valid <= 1'b0;
      mem_note  <= '0;
    end else begin
      state <= state_next;
      Erro  <= acc && !dec.legal;
      if (overrun_set) begin
        Overrun <= 1'b1;
      end
      if (load) begin
        NOTAS     <= dec.code;
        TOM       <= acc_value[SAMPLE_W-1];
        mem_note  <= acc_note;
        mem_valid <= 1'b1;
      end else if (acc && dec.blank) begin
        mem_valid <= 1'b0;
      end
    end
  end

endmodule
